motion_detect_ctrl: RTL and testbench
=====================================

Name: motion_detect_ctrl

Overview:
Frame-level sequencer and input scheduler for motion_detect_top. It accepts two valid/ready pixel streams, background and current frame. Background pixels go to bg_gs. Each frame pixel is written atomically to both frame_gs and frame_hl. The block bounds the skew between the two streams so the grayscale subtract stage cannot deadlock, then drains hl_out into a registered valid/ready output and flags end-of-frame.

Parameters:
WIDTH, 768, image width in pixels
HEIGHT, 576, image height in pixels
DATA_WIDTH, 24, pixel width (BGR, 8 bits each)
MAX_SKEW, 16, maximum |bg_cnt - fr_cnt| of accepted pixels; must be >=1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins one frame of N = WIDTH*HEIGHT pixels
bg_valid  in  1  background pixel valid
bg_data  in  DATA_WIDTH  background pixel
bg_ready  out  1  background pixel accepted when bg_valid & bg_ready
fr_valid  in  1  frame pixel valid
fr_data  in  DATA_WIDTH  frame pixel
fr_ready  out  1  frame pixel accepted when fr_valid & fr_ready
bg_gs_we / bg_gs_din  out  1 / DATA_WIDTH  bg grayscale FIFO write
bg_gs_full  in  1
frame_gs_we / frame_gs_din  out  1 / DATA_WIDTH  frame grayscale FIFO write
frame_gs_full  in  1
frame_hl_we / frame_hl_din  out  1 / DATA_WIDTH  highlight frame FIFO write
frame_hl_full  in  1
hl_out_empty  in  1  result FIFO empty (first-word-fall-through)
hl_out_dout  in  DATA_WIDTH  result FIFO head
hl_out_re  out  1  result FIFO pop
out_valid  out  1  result pixel valid (registered)
out_data  out  DATA_WIDTH  result pixel (registered)
out_last  out  1  qualifies the N-th result pixel
out_ready  in  1  downstream accepts
busy  out  1  high in RUN
done  out  1  one-cycle pulse at frame completion
start_err  out  1  sticky: start seen while busy

Behaviour:
- Reset (reset=0, async): state=IDLE. All counters=0. out_valid, out_data, out_last, done, start_err = 0. All combinational outputs evaluate to 0 in IDLE.
- States are IDLE, RUN, DONE.
  - IDLE->RUN on start; this also clears start_err.
  - RUN->DONE in the cycle the N-th output handshake (out_valid & out_ready & out_last) occurs.
  - DONE->IDLE unconditionally. done=1 only in DONE.
  - busy=1 only in RUN.
  - start in RUN or DONE is ignored and sets start_err.
- Counters bg_cnt, fr_cnt, rd_cnt, out_cnt are each $clog2(N+1) bits, cleared on IDLE->RUN.
- Skew is the signed difference bg_cnt - fr_cnt, computed one bit wider than the counters.
- bg_ready = RUN & bg_cnt<N & !bg_gs_full & skew<MAX_SKEW.
- fr_ready = RUN & fr_cnt<N & !frame_gs_full & !frame_hl_full & -skew<MAX_SKEW.
- Input writes are zero-latency combinational:
  - bg_gs_we = bg_valid & bg_ready, with bg_gs_din = bg_data.
  - frame_gs_we = frame_hl_we = fr_valid & fr_ready, with both din = fr_data.
  - Never write one frame FIFO without the other.
- Both input handshakes may fire in the same cycle; both counters increment.
- Output stage is a one-entry register:
  - hl_out_re = RUN & !hl_out_empty & rd_cnt<N & (!out_valid | out_ready).
  - On hl_out_re: out_data<=hl_out_dout, out_valid<=1, out_last<=(rd_cnt==N-1), rd_cnt++.
  - On out handshake without reload: out_valid<=0, out_last<=0.
  - out_data is stable while out_valid & !out_ready.
- Once bg_cnt==N and fr_cnt==N, both readies stay 0 until the next frame.
- Reset mid-frame abandons the frame. External FIFOs are not flushed by this block.

Optional Feature:
MOTION_DETECT_CTRL_PERF_EN
- Defined: adds output port cycle_count (out, 32 bits). Cleared on IDLE->RUN, increments every RUN cycle, saturates at 2^32-1, holds after done until the next start. Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: drive reset=0 mid-RUN -> within the same cycle busy=0, out_valid=0, bg_ready=fr_ready=0, hl_out_re=0; start_err=0.
- Nominal, WIDTH=4 HEIGHT=2 (N=8): both valids held 1, FIFOs never full, out_ready=1, model FIFO results 0x000001..0x000008. Expect:
  - exactly 8 bg_gs_we and 8 coincident frame_gs_we/frame_hl_we;
  - 8 out beats in order, with out_last only on 0x000008;
  - done pulses once, the cycle after the last beat.
- Skew, MAX_SKEW=4: bg_valid=1, fr_valid=0 -> exactly 4 bg writes, then bg_ready=0. Raise fr_valid for 1 beat -> exactly 1 more bg write allowed.
- Backpressure:
  - frame_hl_full=1, frame_gs_full=0 -> fr_ready=0, no frame_gs_we.
  - out_ready=0 with out_valid=1, data 0xABCDEF -> out_data holds 0xABCDEF, hl_out_re=0 until out_ready=1.
- Protocol: start pulsed in RUN -> start_err=1, counters unchanged, the frame completes normally. The next start in IDLE clears start_err.
- With MOTION_DETECT_CTRL_PERF_EN defined, run the nominal case with no stalls -> cycle_count equals the RUN-cycle count and holds after done.

Source files
------------

// File: rtl/motion_detect_ctrl.sv
// Frame sequencer: feeds bg/frame grayscale FIFOs with bounded skew, drains hl_out to a registered output.
// Latency: input FIFO writes are combinational; an hl_out pop appears on out_data the next cycle.
// Backpressure: readies drop on full FIFOs or skew >= MAX_SKEW; out register holds while !out_ready. Option: MOTION_DETECT_CTRL_PERF_EN.
module motion_detect_ctrl #(
   parameter int WIDTH      = 768,
   parameter int HEIGHT     = 576,
   parameter int DATA_WIDTH = 24,
   parameter int MAX_SKEW   = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  bg_valid,
   input  logic [DATA_WIDTH-1:0] bg_data,
   output logic                  bg_ready,
   input  logic                  fr_valid,
   input  logic [DATA_WIDTH-1:0] fr_data,
   output logic                  fr_ready,
   output logic                  bg_gs_we,
   output logic [DATA_WIDTH-1:0] bg_gs_din,
   input  logic                  bg_gs_full,
   output logic                  frame_gs_we,
   output logic [DATA_WIDTH-1:0] frame_gs_din,
   input  logic                  frame_gs_full,
   output logic                  frame_hl_we,
   output logic [DATA_WIDTH-1:0] frame_hl_din,
   input  logic                  frame_hl_full,
   input  logic                  hl_out_empty,
   input  logic [DATA_WIDTH-1:0] hl_out_dout,
   output logic                  hl_out_re,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  start_err
`ifdef MOTION_DETECT_CTRL_PERF_EN
   ,
   output logic [31:0]           cycle_count
`endif
);

   localparam int N  = WIDTH * HEIGHT;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0]        N_C      = CW'(N);
   localparam logic [CW-1:0]        N_M1     = CW'(N - 1);
   localparam logic signed [CW:0]   SKEW_LIM = (CW+1)'(MAX_SKEW);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CW-1:0]        bg_cnt;
   logic [CW-1:0]        fr_cnt;
   logic [CW-1:0]        rd_cnt;
   logic [CW-1:0]        out_cnt;
   logic signed [CW:0]   skew;
   logic signed [CW:0]   skew_neg;
   logic                 run;
   logic                 frame_start;
   logic                 bg_fire;
   logic                 fr_fire;
   logic                 out_fire;

   assign run         = (state == RUN);
   assign frame_start = (state == IDLE) && start;
   assign out_fire    = out_valid && out_ready;
   assign bg_fire     = bg_valid && bg_ready;
   assign fr_fire     = fr_valid && fr_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (out_fire && out_last && (out_cnt == N_M1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Skew is signed and one bit wider so either stream may lead.
   assign skew     = $signed({1'b0, bg_cnt}) - $signed({1'b0, fr_cnt});
   assign skew_neg = -skew;

   always_comb begin
      bg_ready     = run && (bg_cnt < N_C) && !bg_gs_full && (skew < SKEW_LIM);
      fr_ready     = run && (fr_cnt < N_C) && !frame_gs_full && !frame_hl_full
                     && (skew_neg < SKEW_LIM);
      bg_gs_we     = bg_fire;
      frame_gs_we  = fr_fire;
      frame_hl_we  = fr_fire;
      bg_gs_din    = run ? bg_data : '0;
      frame_gs_din = run ? fr_data : '0;
      frame_hl_din = run ? fr_data : '0;
      hl_out_re    = run && !hl_out_empty && (rd_cnt < N_C) && (!out_valid || out_ready);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bg_cnt  <= '0;
         fr_cnt  <= '0;
         rd_cnt  <= '0;
         out_cnt <= '0;
      end else if (frame_start) begin
         bg_cnt  <= '0;
         fr_cnt  <= '0;
         rd_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         if (bg_fire)         bg_cnt  <= bg_cnt + CW'(1);
         if (fr_fire)         fr_cnt  <= fr_cnt + CW'(1);
         if (hl_out_re)       rd_cnt  <= rd_cnt + CW'(1);
         if (out_fire && run) out_cnt <= out_cnt + CW'(1);
      end
   end

   // A reload in the same cycle as a handshake keeps out_valid high.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (hl_out_re) begin
         out_valid <= 1'b1;
         out_data  <= hl_out_dout;
         out_last  <= (rd_cnt == N_M1);
      end else if (out_fire) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         start_err <= 1'b0;
      end else if (frame_start) begin
         start_err <= 1'b0;
      end else if (start && (state != IDLE)) begin
         start_err <= 1'b1;
      end
   end

`ifdef MOTION_DETECT_CTRL_PERF_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cycle_count <= '0;
      end else if (frame_start) begin
         cycle_count <= '0;
      end else if (run && (cycle_count != 32'hFFFF_FFFF)) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_motion_detect_ctrl.sv
// Bench for motion_detect_ctrl (WIDTH=4, HEIGHT=2, MAX_SKEW=4) with a frame-level reference model.
module tb_motion_detect_ctrl;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int N  = W * H;
   localparam int MS = 4;
   localparam int DW = 24;

   logic          clock, reset, start;
   logic          bg_valid, fr_valid, bg_ready, fr_ready;
   logic [DW-1:0] bg_data, fr_data;
   logic          bg_gs_we, frame_gs_we, frame_hl_we;
   logic [DW-1:0] bg_gs_din, frame_gs_din, frame_hl_din;
   logic          bg_gs_full, frame_gs_full, frame_hl_full;
   logic          hl_out_empty, hl_out_re;
   logic [DW-1:0] hl_out_dout;
   logic          out_valid, out_last, out_ready;
   logic [DW-1:0] out_data;
   logic          busy, done, start_err;
`ifdef MOTION_DETECT_CTRL_PERF_EN
   logic [31:0]   cycle_count;
`endif

   // Result FIFO stand-in: res_mem holds the frame's results, res_n of them are visible.
   logic [DW-1:0] res_mem [16];
   int            res_n, res_base, pops, head;

   assign head         = pops - res_base;
   assign hl_out_empty = (head >= res_n);
   assign hl_out_dout  = (head >= 0 && head < 16) ? res_mem[head] : '0;

   initial pops = 0;
   always @(posedge clock) if (hl_out_re) pops <= pops + 1;

   motion_detect_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .MAX_SKEW(MS)) dut (
      .clock(clock), .reset(reset), .start(start),
      .bg_valid(bg_valid), .bg_data(bg_data), .bg_ready(bg_ready),
      .fr_valid(fr_valid), .fr_data(fr_data), .fr_ready(fr_ready),
      .bg_gs_we(bg_gs_we), .bg_gs_din(bg_gs_din), .bg_gs_full(bg_gs_full),
      .frame_gs_we(frame_gs_we), .frame_gs_din(frame_gs_din), .frame_gs_full(frame_gs_full),
      .frame_hl_we(frame_hl_we), .frame_hl_din(frame_hl_din), .frame_hl_full(frame_hl_full),
      .hl_out_empty(hl_out_empty), .hl_out_dout(hl_out_dout), .hl_out_re(hl_out_re),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .done(done), .start_err(start_err)
`ifdef MOTION_DETECT_CTRL_PERF_EN
      , .cycle_count(cycle_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks, errors;

   // Reference model: phase 0 idle, 1 running, 2 done.
   int            m_ph, m_bg, m_fr, m_rd, m_cyc;
   bit            m_ov, m_ol, m_err;
   logic [DW-1:0] m_od;

   int            tick, n_bgw, n_frw, n_done, last_tick, done_tick;
   logic [DW-1:0] beats [$];
   bit            lasts [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", name, act, exp, tick);
      end
   endtask

   task automatic cmp();
      bit run, ebr, efr, ere, fire;
      tick++;
      if (!reset) begin
         m_ph = 0; m_bg = 0; m_fr = 0; m_rd = 0; m_cyc = 0;
         m_ov = 0; m_ol = 0; m_err = 0; m_od = '0;
      end
      run  = (m_ph == 1);
      ebr  = run && m_bg < N && !bg_gs_full && (m_bg - m_fr) < MS;
      efr  = run && m_fr < N && !frame_gs_full && !frame_hl_full && (m_fr - m_bg) < MS;
      ere  = run && m_rd < res_n && m_rd < N && (!m_ov || out_ready);
      fire = m_ov && out_ready;

      chk("busy", busy, run);
      chk("done", done, m_ph == 2);
      chk("start_err", start_err, m_err);
      chk("bg_ready", bg_ready, ebr);
      chk("fr_ready", fr_ready, efr);
      chk("bg_gs_we", bg_gs_we, ebr && bg_valid);
      chk("frame_gs_we", frame_gs_we, efr && fr_valid);
      chk("frame_hl_we", frame_hl_we, efr && fr_valid);
      chk("hl_out_re", hl_out_re, ere);
      chk("out_valid", out_valid, m_ov);
      chk("out_last", out_last, m_ol);
      if (ebr && bg_valid) chk("bg_gs_din", bg_gs_din, bg_data);
      if (efr && fr_valid) begin
         chk("frame_gs_din", frame_gs_din, fr_data);
         chk("frame_hl_din", frame_hl_din, fr_data);
      end
      if (m_ov) chk("out_data", out_data, m_od);
`ifdef MOTION_DETECT_CTRL_PERF_EN
      chk("cycle_count", cycle_count, m_cyc);
`endif

      if (bg_gs_we) n_bgw++;
      if (frame_gs_we) n_frw++;
      if (done) begin n_done++; done_tick = tick; end
      if (out_valid && out_ready) begin
         beats.push_back(out_data);
         lasts.push_back(out_last);
         if (out_last) last_tick = tick;
      end

      if (reset) begin
         case (m_ph)
            0: if (start) begin
                  m_ph = 1; m_bg = 0; m_fr = 0; m_rd = 0; m_err = 0; m_cyc = 0;
               end
            1: begin
                  m_cyc++;
                  if (ebr && bg_valid) m_bg++;
                  if (efr && fr_valid) m_fr++;
                  if (start) m_err = 1;
                  if (fire && m_ol) m_ph = 2;
               end
            default: begin
                  m_ph = 0;
                  if (start) m_err = 1;
               end
         endcase
         if (ere) begin
            m_od = res_mem[m_rd]; m_ov = 1; m_ol = (m_rd == N - 1); m_rd++;
         end else if (fire) begin
            m_ov = 0; m_ol = 0;
         end
      end
   endtask

   // One cycle: compare on the falling edge, then drive new inputs just after the rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clock);
         cmp();
         @(posedge clock);
         #1;
         bg_data = 24'h100000 + 24'(tick);
         fr_data = 24'h200000 + 24'(tick);
      end
   endtask

   task automatic wait_done(input int d0);
      for (int k = 0; k < 60 && n_done == d0; k++) step(1);
      if (n_done == d0) chk("done_timeout", 0, 1);
   endtask

   int b0, f0, d0;

   initial begin
      checks = 0; errors = 0; tick = 0;
      n_bgw = 0; n_frw = 0; n_done = 0; last_tick = 0; done_tick = 0;
      m_ph = 0; m_bg = 0; m_fr = 0; m_rd = 0; m_cyc = 0; m_ov = 0; m_ol = 0; m_err = 0; m_od = '0;
      reset = 1'b0; start = 1'b0; bg_valid = 1'b0; fr_valid = 1'b0; out_ready = 1'b0;
      bg_data = '0; fr_data = '0; bg_gs_full = 1'b0; frame_gs_full = 1'b0; frame_hl_full = 1'b0;
      res_n = 0; res_base = 0;
      for (int i = 0; i < 16; i++) res_mem[i] = '0;

      step(2);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_start_err", start_err, 0);
      reset = 1'b1;
      step(2);

      // Nominal frame: results 1..8, no stalls.
      for (int i = 0; i < N; i++) res_mem[i] = 24'(i + 1);
      res_n = N; res_base = pops;
      b0 = n_bgw; f0 = n_frw; d0 = n_done; beats.delete(); lasts.delete();
      bg_valid = 1; fr_valid = 1; out_ready = 1; start = 1;
      step(1);
      start = 0;
      wait_done(d0);
      step(2);
      chk("nom_bg_writes", n_bgw - b0, 8);
      chk("nom_fr_writes", n_frw - f0, 8);
      chk("nom_done_count", n_done - d0, 1);
      chk("nom_beats", beats.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk("nom_beat_data", (i < beats.size()) ? beats[i] : 24'hxxxxxx, 24'(i + 1));
         chk("nom_beat_last", (i < lasts.size()) ? 32'(lasts[i]) : 32'hx, (i == 7) ? 1 : 0);
      end
      chk("nom_done_lag", done_tick - last_tick, 1);
`ifdef MOTION_DETECT_CTRL_PERF_EN
      chk("perf_run_cycles", cycle_count, 9);
`endif
      bg_valid = 0; fr_valid = 0;

      // Skew, frame-FIFO backpressure, start-in-RUN and output hold in one frame.
      res_mem[0] = 24'hABCDEF;
      for (int i = 1; i < N; i++) res_mem[i] = 24'h000010 + 24'(i);
      res_n = 0; res_base = pops;
      b0 = n_bgw; d0 = n_done; beats.delete(); lasts.delete();
      out_ready = 0; bg_valid = 1; start = 1;
      step(1);
      start = 0;
      step(8);
      chk("skew_bg_writes", n_bgw - b0, 4);
      chk("skew_bg_ready_low", bg_ready, 0);
      fr_valid = 1;
      step(1);
      fr_valid = 0;
      step(6);
      chk("skew_bg_after_fr", n_bgw - b0, 5);

      frame_hl_full = 1; fr_valid = 1; f0 = n_frw;
      step(3);
      chk("hl_full_fr_ready", fr_ready, 0);
      chk("hl_full_no_gs_we", n_frw - f0, 0);
      frame_hl_full = 0;

      start = 1;
      step(1);
      start = 0;
      chk("start_err_set", start_err, 1);
      chk("start_err_busy", busy, 1);
      step(12);

      res_n = 3;
      step(4);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 24'hABCDEF);
      chk("hold_no_re", hl_out_re, 0);
      step(2);
      chk("hold_data_later", out_data, 24'hABCDEF);
      res_n = N; out_ready = 1;
      wait_done(d0);
      step(1);
      chk("bp_first_beat", (beats.size() > 0) ? beats[0] : 24'hxxxxxx, 24'hABCDEF);
      chk("bp_beats", beats.size(), 8);
      chk("start_err_sticky", start_err, 1);
      bg_valid = 0; fr_valid = 0;

      // Fresh start clears start_err; then reset mid-frame.
      for (int i = 0; i < N; i++) res_mem[i] = 24'(i + 1);
      res_n = N; res_base = pops;
      start = 1;
      step(1);
      start = 0;
      chk("start_err_cleared", start_err, 0);
      bg_valid = 1; fr_valid = 1; out_ready = 1;
      step(3);
      start = 1;
      step(1);
      start = 0;
      chk("start_err_again", start_err, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_bg_ready", bg_ready, 0);
      chk("mid_rst_fr_ready", fr_ready, 0);
      chk("mid_rst_hl_out_re", hl_out_re, 0);
      chk("mid_rst_start_err", start_err, 0);
      step(1);
      reset = 1'b1;
      bg_valid = 0; fr_valid = 0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
